// File: rtl/z80_sys_pkg.sv
// Shared types and sizing helpers for the Z80 system controller.
package z80_sys_pkg;

  // Wait-state counter width; covers 0..15 wait states.
  localparam int unsigned WaitCntW = 4;

  // Width needed to hold a reset count of 0..cycles inclusive.
  function automatic int unsigned rst_cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  typedef enum logic {
    StIdle,
    StWaiting
  } wait_state_e;

  typedef enum logic {
    StHold,
    StRun
  } rst_state_e;

endpackage

// File: rtl/z80_wait_gen.sv
// Per-region wait-state generator driving the Z80 nWAIT input.
module z80_wait_gen
  import z80_sys_pkg::*;
#(
  parameter int unsigned LO_WAIT = 0,
  parameter int unsigned HI_WAIT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic access_i,
  input  logic region_i,
  input  logic fall_stb_i,
  input  logic abort_i,
  output logic wait_n_o
);

  wait_state_e          state_q, state_d;
  logic [WaitCntW-1:0]  cnt_q, cnt_d;
  logic                 idle_q;
  logic                 start;
  logic [WaitCntW-1:0]  load_val;

  // A new access only starts a wait if the bus was idle the clock before.
  assign start    = access_i & idle_q;
  assign load_val = region_i ? WaitCntW'(HI_WAIT) : WaitCntW'(LO_WAIT);

  // State, counter and idle-history registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= ~access_i;
    end
  end

  // Next-state: load on start, count down on cpu_clk falling edges, abort wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_d = load_val;
            if (load_val != '0) state_d = StWaiting;
          end
        end
        StWaiting: begin
          if (!access_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (fall_stb_i) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == WaitCntW'(1)) state_d = StIdle;
          end
        end
      endcase
    end
  end

  // nWAIT is low for exactly the time spent in the waiting state.
  always_comb begin
    wait_n_o = (state_q != StWaiting);
  end

endmodule

// File: rtl/z80_sys_ctrl.sv
// CPU-side system controller: clock divider, reset sequencer, chip-select
// decoder and wait-state generator for the Z80 core.
module z80_sys_ctrl
  import z80_sys_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned RESET_CYCLES = 8,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned SPLIT_BIT    = 15,
  parameter int unsigned LO_WAIT      = 0,
  parameter int unsigned HI_WAIT      = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              soft_rst_i,
  output logic              cpu_clk_o,
  output logic              cpu_reset_n_o,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_rd_n_i,
  input  logic              cpu_wr_n_i,
  input  logic              cpu_rfsh_n_i,
  output logic              cpu_wait_n_o,
  output logic              lo_ce_n_o,
  output logic              hi_ce_n_o
);

  localparam int unsigned Half    = CLK_DIV / 2;
  localparam int unsigned DivW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RstCntW = rst_cnt_w(RESET_CYCLES);

  logic [DivW-1:0]    div_cnt_q;
  logic               cpu_clk_q;
  logic               rise_stb, fall_stb;
  rst_state_e         rst_state_q, rst_state_d;
  logic [RstCntW-1:0] rst_cnt_q, rst_cnt_d;
  logic               access, region, abort;
  logic               unused_addr;

  assign rise_stb  = (div_cnt_q == DivW'(Half - 1));
  assign fall_stb  = (div_cnt_q == DivW'(CLK_DIV - 1));
  assign cpu_clk_o = cpu_clk_q;

  // Free-running divider; soft reset deliberately leaves it alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      cpu_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= fall_stb ? '0 : div_cnt_q + 1'b1;
      if (rise_stb)      cpu_clk_q <= 1'b1;
      else if (fall_stb) cpu_clk_q <= 1'b0;
    end
  end

  // Reset sequencer state and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_state_q <= StHold;
      rst_cnt_q   <= '0;
    end else begin
      rst_state_q <= rst_state_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  // Count cpu_clk rises while held; release on the following falling edge.
  always_comb begin
    rst_state_d = rst_state_q;
    rst_cnt_d   = rst_cnt_q;
    if (soft_rst_i) begin
      rst_state_d = StHold;
      rst_cnt_d   = '0;
    end else begin
      unique case (rst_state_q)
        StHold: begin
          if (rise_stb && (rst_cnt_q != RstCntW'(RESET_CYCLES))) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
          if ((rst_cnt_q == RstCntW'(RESET_CYCLES)) && fall_stb) begin
            rst_state_d = StRun;
          end
        end
        StRun: ;
      endcase
    end
  end

  // CPU reset is released exactly while the sequencer is running.
  always_comb begin
    cpu_reset_n_o = (rst_state_q == StRun);
  end

  // Refresh cycles and anything during CPU reset never select a device.
  assign access      = (~cpu_rd_n_i | ~cpu_wr_n_i) & cpu_rfsh_n_i & cpu_reset_n_o;
  assign region      = cpu_addr_i[SPLIT_BIT];
  assign lo_ce_n_o   = ~(access & ~region);
  assign hi_ce_n_o   = ~(access & region);
  assign abort       = ~cpu_reset_n_o | soft_rst_i;
  assign unused_addr = ^cpu_addr_i;

  z80_wait_gen #(
    .LO_WAIT (LO_WAIT),
    .HI_WAIT (HI_WAIT)
  ) u_wait_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .access_i   (access),
    .region_i   (region),
    .fall_stb_i (fall_stb),
    .abort_i    (abort),
    .wait_n_o   (cpu_wait_n_o)
  );

endmodule

// File: tb/tb_z80_sys_ctrl.sv
// Directed bench for z80_sys_ctrl using three differently parameterised instances.
module tb_z80_sys_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   vecs = 0;
  int   errs = 0;

  // Instance A: CLK_DIV=4, RESET_CYCLES=4, HI_WAIT=5
  logic        soft_a = 1'b0, rd_n_a = 1'b1, wr_n_a = 1'b1, rfsh_n_a = 1'b1;
  logic [15:0] addr_a = 16'h0000;
  logic        cpu_clk_a, reset_n_a, wait_n_a, lo_ce_a, hi_ce_a;
  // Instance B: CLK_DIV=2, RESET_CYCLES=2, LO_WAIT=0, HI_WAIT=2
  logic        soft_b = 1'b0, rd_n_b = 1'b1, wr_n_b = 1'b1, rfsh_n_b = 1'b1;
  logic [15:0] addr_b = 16'h0000;
  logic        cpu_clk_b, reset_n_b, wait_n_b, lo_ce_b, hi_ce_b;
  // Instance C: CLK_DIV=2, RESET_CYCLES=2, HI_WAIT=15
  logic        soft_c = 1'b0, rd_n_c = 1'b1, wr_n_c = 1'b1, rfsh_n_c = 1'b1;
  logic [15:0] addr_c = 16'h0000;
  logic        cpu_clk_c, reset_n_c, wait_n_c, lo_ce_c, hi_ce_c;

  always #5 clk = ~clk;

  // Edge 1 is the first rising clk edge after reset release.
  always @(posedge clk) if (!rst) edge_n <= edge_n + 1;

  z80_sys_ctrl #(.CLK_DIV(4), .RESET_CYCLES(4), .ADDR_W(16), .SPLIT_BIT(15),
                 .LO_WAIT(0), .HI_WAIT(5)) dut_a (
    .clk_i(clk), .rst_i(rst), .soft_rst_i(soft_a), .cpu_clk_o(cpu_clk_a),
    .cpu_reset_n_o(reset_n_a), .cpu_addr_i(addr_a), .cpu_rd_n_i(rd_n_a),
    .cpu_wr_n_i(wr_n_a), .cpu_rfsh_n_i(rfsh_n_a), .cpu_wait_n_o(wait_n_a),
    .lo_ce_n_o(lo_ce_a), .hi_ce_n_o(hi_ce_a));

  z80_sys_ctrl #(.CLK_DIV(2), .RESET_CYCLES(2), .ADDR_W(16), .SPLIT_BIT(15),
                 .LO_WAIT(0), .HI_WAIT(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .soft_rst_i(soft_b), .cpu_clk_o(cpu_clk_b),
    .cpu_reset_n_o(reset_n_b), .cpu_addr_i(addr_b), .cpu_rd_n_i(rd_n_b),
    .cpu_wr_n_i(wr_n_b), .cpu_rfsh_n_i(rfsh_n_b), .cpu_wait_n_o(wait_n_b),
    .lo_ce_n_o(lo_ce_b), .hi_ce_n_o(hi_ce_b));

  z80_sys_ctrl #(.CLK_DIV(2), .RESET_CYCLES(2), .ADDR_W(16), .SPLIT_BIT(15),
                 .LO_WAIT(0), .HI_WAIT(15)) dut_c (
    .clk_i(clk), .rst_i(rst), .soft_rst_i(soft_c), .cpu_clk_o(cpu_clk_c),
    .cpu_reset_n_o(reset_n_c), .cpu_addr_i(addr_c), .cpu_rd_n_i(rd_n_c),
    .cpu_wr_n_i(wr_n_c), .cpu_rfsh_n_i(rfsh_n_c), .cpu_wait_n_o(wait_n_c),
    .lo_ce_n_o(lo_ce_c), .hi_ce_n_o(hi_ce_c));

  task automatic chk(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Return at the falling clk edge following rising edge k (bounded by k).
  task automatic at(input int k);
    while (edge_n < k) @(negedge clk);
  endtask

  initial begin
    // Reset state; a read on B during reset must select nothing.
    rd_n_b = 1'b0; addr_b = 16'h8000;
    repeat (2) @(negedge clk);
    chk("rst_cpu_clk_a", cpu_clk_a, 1'b0);
    chk("rst_reset_n_a", reset_n_a, 1'b0);
    chk("rst_wait_n_a",  wait_n_a,  1'b1);
    chk("rst_lo_ce_b",   lo_ce_b,   1'b1);
    chk("rst_hi_ce_b",   hi_ce_b,   1'b1);
    chk("rst_wait_n_b",  wait_n_b,  1'b1);
    rst = 1'b0;

    // Divider waveform on A (rise when div_cnt==1, fall when div_cnt==3).
    at(1);  chk("a_clk_e1", cpu_clk_a, 1'b0);
            chk("b_hold_hi_ce", hi_ce_b, 1'b1);
            chk("b_hold_wait", wait_n_b, 1'b1);
    at(2);  chk("a_clk_e2", cpu_clk_a, 1'b1);
            rd_n_b = 1'b1;
    at(3);  chk("a_clk_e3", cpu_clk_a, 1'b1);
            chk("b_rstn_e3", reset_n_b, 1'b0);
    at(4);  chk("a_clk_e4", cpu_clk_a, 1'b0);
            chk("b_rstn_e4", reset_n_b, 1'b1);
            chk("b_clk_e4", cpu_clk_b, 1'b0);
    at(5);  chk("a_clk_e5", cpu_clk_a, 1'b0);
            chk("b_clk_e5", cpu_clk_b, 1'b1);
    at(6);  chk("a_clk_e6", cpu_clk_a, 1'b1);
    at(15); chk("a_rstn_e15", reset_n_a, 1'b0);
    at(16); chk("a_rstn_e16", reset_n_a, 1'b1);

    // High-region read on B: two wait states.
    at(20); rd_n_b = 1'b0; addr_b = 16'h8000;
            #1;
            chk("b_hi_rd_hi_ce", hi_ce_b, 1'b0);
            chk("b_hi_rd_lo_ce", lo_ce_b, 1'b1);
    at(21); chk("b_wait_e21", wait_n_b, 1'b0);
    at(22); chk("b_wait_e22", wait_n_b, 1'b0);
    at(23); chk("b_wait_e23", wait_n_b, 1'b0);
    at(24); chk("b_wait_e24", wait_n_b, 1'b1);
    at(25); chk("b_no_restart", wait_n_b, 1'b1);
            rd_n_b = 1'b1;

    // Low-region write on B: zero wait states.
    at(26); wr_n_b = 1'b0; addr_b = 16'h1234;
            #1;
            chk("b_lo_wr_lo_ce", lo_ce_b, 1'b0);
            chk("b_lo_wr_hi_ce", hi_ce_b, 1'b1);
    at(27); chk("b_lo_wait_e27", wait_n_b, 1'b1);
    at(29); chk("b_lo_wait_e29", wait_n_b, 1'b1);
            wr_n_b = 1'b1;

    // Refresh cycle on B: nothing selected, no wait.
    at(30); rfsh_n_b = 1'b0; rd_n_b = 1'b0; addr_b = 16'h8000;
            #1;
            chk("b_rfsh_lo_ce", lo_ce_b, 1'b1);
            chk("b_rfsh_hi_ce", hi_ce_b, 1'b1);
    at(32); chk("b_rfsh_wait", wait_n_b, 1'b1);
            rfsh_n_b = 1'b1; rd_n_b = 1'b1;

    // C: 15-wait read aborted after 3 falls, then a fresh access reloads 15.
            rd_n_c = 1'b0; addr_c = 16'h8000;
    at(33); chk("c_wait_e33", wait_n_c, 1'b0);
    at(38); chk("c_wait_e38", wait_n_c, 1'b0);
            rd_n_c = 1'b1;
    at(39); chk("c_abort_e39", wait_n_c, 1'b1);
    at(40); rd_n_c = 1'b0;
    at(41); chk("c_reload_e41", wait_n_c, 1'b0);
    at(69); chk("c_reload_e69", wait_n_c, 1'b0);
    at(70); chk("c_reload_e70", wait_n_c, 1'b1);
            rd_n_c = 1'b1;

    // A: soft reset in the middle of a 5-wait access.
            rd_n_a = 1'b0; addr_a = 16'h8000;
    at(71); chk("a_wait_e71", wait_n_a, 1'b0);
            chk("a_hi_ce_e71", hi_ce_a, 1'b0);
    at(76); chk("a_wait_e76", wait_n_a, 1'b0);
            soft_a = 1'b1;
    at(77); chk("a_soft_rstn", reset_n_a, 1'b0);
            chk("a_soft_wait", wait_n_a, 1'b1);
            soft_a = 1'b0; rd_n_a = 1'b1;
    at(78); chk("a_clk_e78", cpu_clk_a, 1'b1);
    at(80); chk("a_clk_e80", cpu_clk_a, 1'b0);
    at(91); chk("a_rstn_e91", reset_n_a, 1'b0);
    at(92); chk("a_rstn_e92", reset_n_a, 1'b1);
            soft_a = 1'b1; rd_n_c = 1'b0; addr_c = 16'h8000;
    at(93); chk("a_rstn_e93", reset_n_a, 1'b0);
            chk("c_wait_e93", wait_n_c, 1'b0);
            chk("c_hi_ce_e93", hi_ce_c, 1'b0);
            soft_a = 1'b0;
    at(95); chk("a_clk_e95", cpu_clk_a, 1'b1);
            chk("c_clk_e95", cpu_clk_c, 1'b1);

    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_a",    cpu_clk_a, 1'b0);
    chk("arst_rstn_a",   reset_n_a, 1'b0);
    chk("arst_wait_c",   wait_n_c,  1'b1);
    chk("arst_clk_c",    cpu_clk_c, 1'b0);
    chk("arst_rstn_c",   reset_n_c, 1'b0);
    chk("arst_hi_ce_c",  hi_ce_c,   1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
